intersection_phase_scheduler: RTL
=================================

Name: intersection_phase_scheduler

Overview:
- Sequences a four-approach intersection.
- Grants green to one approach at a time, round-robin among approaches with pending vehicle-sensor requests.
- Inserts a yellow interval and an all-red clearance between greens.
- Honours an emergency preempt.
- Drives the per-approach 3-bit lamp outputs; sits above the single-signal light sequencer and replaces its fixed cycle.

Parameters:
- N_APPR, 4, number of approaches (fixed at 4 for this revision; index width 2).
- MIN_GREEN, 5, minimum green duration in cycles (>=1).
- MAX_GREEN, 20, maximum green duration in cycles when another approach is waiting (>=MIN_GREEN).
- YELLOW_T, 3, yellow duration in cycles (>=1).
- ALLRED_T, 2, all-red clearance duration in cycles (>=1).
- CNT_W, 8, phase counter width; must hold MAX_GREEN-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req  input  N_APPR  level vehicle-sensor request per approach
- preempt  input  1  emergency preempt request, level
- preempt_dir  input  2  approach to serve under preempt
- lights  output  3*N_APPR  lamps for approach i at [3i+2:3i]; 100=red, 010=green, 001=yellow
- active_dir  output  2  approach currently green/yellow
- phase  output  2  current phase encoding (IDLE/GREEN/YELLOW/ALLRED)
- preempt_active  output  1  high while green is held for preempt_dir

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values: phase=IDLE, count=0, active_dir=0, last_served=3, all lights=100, preempt_active=0.
- Outputs are decoded from registered state (no added latency).
- In ALLRED and IDLE every approach shows 100.
- In GREEN and YELLOW only active_dir shows 010/001; all other approaches show 100.
- count resets to 0 on every phase entry and increments each cycle. In GREEN it saturates at MAX_GREEN-1.
- Round-robin pick: first i with req[i]=1 scanning last_served+1, +2, ... modulo 4. The current approach is checked last.
- IDLE:
  - preempt=1 -> GREEN, active_dir=preempt_dir.
  - else any req -> GREEN, active_dir=pick.
  - else stay IDLE.
  - Request seen in cycle t gives green in cycle t+1.
- GREEN:
  - On entry, last_served<=active_dir.
  - If preempt=1 and preempt_dir!=active_dir -> YELLOW next cycle, MIN_GREEN ignored.
  - If preempt=1 and preempt_dir==active_dir -> hold GREEN, preempt_active=1.
  - Otherwise, once count>=MIN_GREEN-1: if another approach requests and (req[active_dir]=0 or count==MAX_GREEN-1) -> YELLOW.
  - If no other approach requests, rest on green indefinitely, including when req[active_dir]=0.
- YELLOW: exactly YELLOW_T cycles, then ALLRED. Not shortened or extended by preempt.
- ALLRED: exactly ALLRED_T cycles. On exit:
  - preempt=1 -> GREEN preempt_dir.
  - else any req -> GREEN pick.
  - else IDLE.
- Green-to-green gap is YELLOW_T+ALLRED_T cycles. Never two non-red approaches simultaneously; no GREEN->GREEN transition without YELLOW and ALLRED.
- Requests are sampled only at decision points and are not latched. A request dropped before its turn is skipped.
- Reset mid-phase: all lights red immediately (async). First grant after release follows the IDLE rules.
- Undefined phase encodings recover to IDLE with all red.

Decomposition:
- Package tl_pkg: phase_t enum (IDLE=2'b00, GREEN=2'b01, YELLOW=2'b10, ALLRED=2'b11), lamp constants LAMP_RED=3'b100, LAMP_GREEN=3'b010, LAMP_YELLOW=3'b001.
- Sub-module rr_pick: combinational round-robin finder. Inputs req[3:0] and last[1:0]; outputs idx[1:0] and any.

Test Plan:
- Reset, then req=0001 at cycle 3 -> cycle 4 lights[2:0]=010, other approaches 100. req dropped at cycle 6 with no other requests -> green held.
- Approach 0 green, req=0011 held continuously -> green exactly 20 cycles, yellow 3, all-red 2, then approach 1 gets 010.
- Approach 0 green, req[0] drops at count 2 while req[2]=1 -> yellow starts after count 4 (5 green cycles), approach 1 skipped, approach 2 green after 5 clearance cycles.
- Approach 1 green at count 1, preempt=1 with preempt_dir=3 -> yellow next cycle, 3+2 clearance, then approach 3 green with preempt_active=1 held while preempt stays high despite req=1111.
- All four requesting continuously -> grant order 0,1,2,3,0. No cycle has two non-100 lamp fields.
- rst asserted during YELLOW -> lights=all 100 in the same cycle, phase=IDLE. After release with req=0100 -> approach 2 green one cycle later.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: phase encoding and lamp patterns shared by the intersection scheduler
package tl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    ALLRED = 2'b11
  } phase_t;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin finder; req[3:0] and last[1:0] in, idx = first requester after last (last itself checked last), any = some request
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       any
);
  logic [1:0] c;
  always_comb begin
    idx = last;
    c = last;
    for (int k = 4; k >= 1; k--) begin
      c = last + 2'(k);
      idx = req[c] ? c : idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: four-approach round-robin green/yellow/all-red sequencer with preempt; clk, rst, req, preempt, preempt_dir in; lights, active_dir, phase, preempt_active out
module intersection_phase_scheduler
  import tl_pkg::*;
#(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_APPR-1:0]     req,
  input  logic                  preempt,
  input  logic [1:0]            preempt_dir,
  output logic [3*N_APPR-1:0]   lights,
  output logic [1:0]            active_dir,
  output logic [1:0]            phase,
  output logic                  preempt_active
);
  phase_t           ph;
  logic [CNT_W-1:0] count;
  logic [1:0]       last_served;
  logic [1:0]       pick;
  logic             any;
  logic [1:0]       grant_dir;
  logic             grant;
  logic [3:0]       others;
  logic             leave_green;
  rr_pick u_pick (
    .req (req),
    .last(last_served),
    .idx (pick),
    .any (any)
  );
  assign grant_dir = preempt ? preempt_dir : pick;
  assign grant = preempt | any;
  assign others = req & ~(4'b0001 << active_dir);
  // a foreign preempt cuts green short regardless of MIN_GREEN; a matching one pins it
  assign leave_green = preempt ? (preempt_dir != active_dir)
                     : (count >= CNT_W'(MIN_GREEN - 1)) && (|others)
                       && (!req[active_dir] || count == CNT_W'(MAX_GREEN - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= IDLE;
      count <= '0;
      active_dir <= 2'd0;
      last_served <= 2'd3;
      preempt_active <= 1'b0;
    end else begin
      preempt_active <= 1'b0;
      case (ph)
        IDLE: begin
          count <= '0;
          if (grant) begin
            ph <= GREEN;
            active_dir <= grant_dir;
            last_served <= grant_dir;
            preempt_active <= preempt;
          end
        end
        GREEN: begin
          if (leave_green) begin
            ph <= YELLOW;
            count <= '0;
          end else begin
            count <= (count == CNT_W'(MAX_GREEN - 1)) ? count : count + 1'b1;
            preempt_active <= preempt;
          end
        end
        YELLOW: begin
          ph <= (count == CNT_W'(YELLOW_T - 1)) ? ALLRED : YELLOW;
          count <= (count == CNT_W'(YELLOW_T - 1)) ? '0 : count + 1'b1;
        end
        ALLRED: begin
          if (count == CNT_W'(ALLRED_T - 1)) begin
            count <= '0;
            ph <= grant ? GREEN : IDLE;
            if (grant) begin
              active_dir <= grant_dir;
              last_served <= grant_dir;
              preempt_active <= preempt;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          ph <= IDLE;
          count <= '0;
        end
      endcase
    end
  end
  assign phase = ph;
  for (genvar g = 0; g < N_APPR; g++) begin : g_lamp
    assign lights[3*g +: 3] = (ph == GREEN && active_dir == 2'(g)) ? LAMP_GREEN
                            : (ph == YELLOW && active_dir == 2'(g)) ? LAMP_YELLOW : LAMP_RED;
  end
endmodule
